pipeline_controller: RTL

- Registered successor to the combinational opcode decoder for the 5-stage MIPS pipeline.
- Decodes the IF/ID opcode into a control bundle and registers it into the ID/EX stage.
- Owns hazard control: load-use bubbles, a multi-cycle multiply busy stall, and branch/jump flushes.
- Generates per-stage write enables with a pipeline-fill sequence after reset.

---
 rtl/pipeline_controller_if.sv | 46 ++++
 rtl/pipeline_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_controller_if.sv
// Control-path bundle between the IF/ID stage, the hazard inputs from EX
// and the registered ID/EX control fields produced by pipeline_controller.
interface pipeline_controller_if #(
    parameter int ALUOP_W    = 5,
    parameter int NUM_STAGES = 3,
    parameter int REG_ADDR_W = 5
);
    logic [5:0]            OpCode;
    logic [REG_ADDR_W-1:0] IFID_Rs;
    logic [REG_ADDR_W-1:0] IFID_Rt;
    logic                  IDEX_MemRead;
    logic [REG_ADDR_W-1:0] IDEX_Rt;
    logic                  BranchTaken;

    logic [1:0]            RegDest;
    logic [1:0]            MemToReg;
    logic [1:0]            ByteSel;
    logic                  RegWrite;
    logic                  AluSrc;
    logic                  MemWrite;
    logic                  MemRead;
    logic                  Branch;
    logic                  SignExt;
    logic                  Jump;
    logic                  JumpMux;
    logic [ALUOP_W-1:0]    AluOp;
    logic                  PCWrite;
    logic                  IFID_Write;
    logic                  IFID_Flush;
    logic                  Busy;
    logic [NUM_STAGES-1:0] StageWriteEnable;

    modport master (
        output OpCode, IFID_Rs, IFID_Rt, IDEX_MemRead, IDEX_Rt, BranchTaken,
        input  RegDest, MemToReg, ByteSel, RegWrite, AluSrc, MemWrite,
        input  MemRead, Branch, SignExt, Jump, JumpMux, AluOp,
        input  PCWrite, IFID_Write, IFID_Flush, Busy, StageWriteEnable
    );

    modport slave (
        input  OpCode, IFID_Rs, IFID_Rt, IDEX_MemRead, IDEX_Rt, BranchTaken,
        output RegDest, MemToReg, ByteSel, RegWrite, AluSrc, MemWrite,
        output MemRead, Branch, SignExt, Jump, JumpMux, AluOp,
        output PCWrite, IFID_Write, IFID_Flush, Busy, StageWriteEnable
    );
endinterface

// File: rtl/pipeline_controller.sv
// Registered ID-stage controller: opcode decode into the ID/EX bundle,
// load-use bubbles, multi-cycle multiply stall and branch/jump flushes.
module pipeline_controller #(
    parameter int ALUOP_W    = 5,
    parameter int NUM_STAGES = 3,
    parameter int MUL_CYCLES = 4,
    parameter int REG_ADDR_W = 5
) (
    input  logic                 Clk,
    input  logic                 Rst,
    pipeline_controller_if.slave bus
);

    localparam int CNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'((MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0);

    typedef struct packed {
        logic [1:0]         reg_dest;
        logic [1:0]         mem_to_reg;
        logic [1:0]         byte_sel;
        logic               reg_write;
        logic               alu_src;
        logic               mem_write;
        logic               mem_read;
        logic               branch;
        logic               sign_ext;
        logic               jump;
        logic               jump_mux;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    typedef enum logic {RUN, MUL_BUSY} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    ctrl_t                 ctrl_q, ctrl_d;
    logic [NUM_STAGES-1:0] swe_q, swe_d;

    ctrl_t dec;
    logic  dec_mul;
    logic  hazard;
    logic  pc_write, ifid_write, ifid_flush;

    function automatic logic [ALUOP_W-1:0] aop(input logic [4:0] c);
        return ALUOP_W'(c);
    endfunction

    // Opcode decode table; anything not listed stays a NOP.
    always_comb begin
        dec     = '0;
        dec_mul = 1'b0;
        case (bus.OpCode)
            6'b000000: begin
                dec.reg_write = 1'b1;
                dec.sign_ext  = 1'b1;
                dec.jump_mux  = 1'b1;
            end
            6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
                dec.reg_dest   = 2'b01;
                dec.branch     = 1'b1;
                dec.mem_to_reg = 2'b11;
                dec.sign_ext   = 1'b1;
            end
            6'b000010: begin
                dec.jump     = 1'b1;
                dec.sign_ext = 1'b1;
            end
            6'b000011: begin
                dec.reg_dest   = 2'b10;
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 2'b10;
                dec.jump       = 1'b1;
                dec.sign_ext   = 1'b1;
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
                dec.reg_dest  = 2'b01;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.sign_ext  = (bus.OpCode != 6'b001001);
            end
            6'b011100: begin
                dec.reg_write = 1'b1;
                dec.sign_ext  = 1'b1;
                dec_mul       = 1'b1;
            end
            6'b011111: begin
                dec.reg_write = 1'b1;
            end
            6'b100000, 6'b100001, 6'b100011: begin
                dec.reg_dest   = 2'b01;
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 2'b01;
                dec.sign_ext   = 1'b1;
            end
            6'b101000, 6'b101001, 6'b101011: begin
                dec.reg_dest   = 2'b01;
                dec.alu_src    = 1'b1;
                dec.mem_write  = 1'b1;
                dec.mem_to_reg = 2'b11;
                dec.sign_ext   = 1'b1;
            end
            default: ;
        endcase
        case (bus.OpCode)
            6'b000001: dec.alu_op = aop(5'b10000);
            6'b000100: dec.alu_op = aop(5'b01110);
            6'b000101: dec.alu_op = aop(5'b01111);
            6'b000110: dec.alu_op = aop(5'b10010);
            6'b000111: dec.alu_op = aop(5'b10001);
            6'b001000: dec.alu_op = aop(5'b00001);
            6'b001001: dec.alu_op = aop(5'b00111);
            6'b001010: dec.alu_op = aop(5'b01010);
            6'b001011: dec.alu_op = aop(5'b01011);
            6'b001100: dec.alu_op = aop(5'b00100);
            6'b001101: dec.alu_op = aop(5'b00011);
            6'b001110: dec.alu_op = aop(5'b00101);
            6'b001111: dec.alu_op = aop(5'b10011);
            6'b011100: dec.alu_op = aop(5'b01100);
            6'b011111: dec.alu_op = aop(5'b01101);
            6'b100000, 6'b100001, 6'b100011,
            6'b101000, 6'b101001, 6'b101011: dec.alu_op = aop(5'b00001);
            default: ;
        endcase
        case (bus.OpCode)
            6'b100000, 6'b101000: dec.byte_sel = 2'b01;
            6'b100001, 6'b101001: dec.byte_sel = 2'b11;
            default: ;
        endcase
    end

    assign hazard = bus.IDEX_MemRead &&
                    (bus.IDEX_Rt != REG_ADDR_W'(0)) &&
                    ((bus.IDEX_Rt == bus.IFID_Rs) ||
                     (bus.IDEX_Rt == bus.IFID_Rt));

    // Hazard priority, multiply stall sequencing and next ID/EX bundle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        ctrl_d     = '0;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.BranchTaken) begin
                    ifid_flush = 1'b1;
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                end else if (!hazard) begin
                    ctrl_d     = dec;
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    ifid_flush = dec.jump;
                    if (dec_mul && (MUL_CYCLES > 1)) begin
                        cnt_d   = CNT_INIT;
                        busy_d  = 1'b1;
                        state_d = MUL_BUSY;
                    end
                end
            end
            MUL_BUSY: begin
                ifid_flush = bus.BranchTaken;
                if (cnt_q == '0) begin
                    state_d = RUN;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Pipeline-fill shift: one more stage enabled on every edge after reset.
    assign swe_d = NUM_STAGES'({swe_q, 1'b1});

    // Controller state and registered outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ctrl_q  <= '0;
            swe_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ctrl_q  <= ctrl_d;
            swe_q   <= swe_d;
        end
    end

    assign bus.PCWrite          = pc_write & ~Rst;
    assign bus.IFID_Write       = ifid_write & ~Rst;
    assign bus.IFID_Flush       = ifid_flush & ~Rst;
    assign bus.Busy             = busy_q;
    assign bus.StageWriteEnable = swe_q;

    assign bus.RegDest  = ctrl_q.reg_dest;
    assign bus.MemToReg = ctrl_q.mem_to_reg;
    assign bus.ByteSel  = ctrl_q.byte_sel;
    assign bus.RegWrite = ctrl_q.reg_write;
    assign bus.AluSrc   = ctrl_q.alu_src;
    assign bus.MemWrite = ctrl_q.mem_write;
    assign bus.MemRead  = ctrl_q.mem_read;
    assign bus.Branch   = ctrl_q.branch;
    assign bus.SignExt  = ctrl_q.sign_ext;
    assign bus.Jump     = ctrl_q.jump;
    assign bus.JumpMux  = ctrl_q.jump_mux;
    assign bus.AluOp    = ctrl_q.alu_op;

endmodule
